// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
//   Memory-access stage of the PQR5 core. Takes the registered load/store
//   command from the EXU, issues one outstanding data-memory request with
//   byte enables, stalls upstream until the access completes, then aligns
//   and sign/zero-extends load data for write-back.
//
// Optional feature (compile-time macro): DMEM_MISALIGN_CHK_EN
//   defined   : misaligned HWORD/WORD accesses are not issued; the stage goes
//               straight to DONE with o_misalign = 1 and o_load_data = 0.
//   undefined : o_misalign is always 0; every access is issued as-is.
//
// Ports
//   clk, aresetn          clock, asynchronous active-low reset
//   i_mem_cmd             0 = load, 1 = store
//   i_mem_addr            byte address
//   i_mem_size            00 byte, 01 half-word, 1x word
//   i_mem_unsigned        zero-extend loads
//   i_mem_data            store data, already lane-shifted
//   i_bubble              no valid instruction on the inputs
//   o_stall               hold upstream stage
//   i_stall               downstream (write-back) stall
//   o_dmem_req/we/addr/be/wdata   data-memory request channel
//   i_dmem_gnt            request accepted
//   i_dmem_rvalid/rdata   read response
//   o_load_data           aligned, extended load result (0 for stores)
//   o_misalign            misaligned-access flag
//   o_bubble              no valid result
// ---------------------------------------------------------------------------
module dmem_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            i_mem_cmd,
    input  logic [XLEN-1:0] i_mem_addr,
    input  logic [1:0]      i_mem_size,
    input  logic            i_mem_unsigned,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic            i_bubble,
    output logic            o_stall,
    input  logic            i_stall,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_misalign,
    output logic            o_bubble
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_cmd;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [1:0]      r_lane;
    logic            r_dmem_req;
    logic            r_dmem_we;
    logic [XLEN-1:0] r_dmem_addr;
    logic [3:0]      r_dmem_be;
    logic [XLEN-1:0] r_dmem_wdata;
    logic [XLEN-1:0] r_load_data;
    logic            r_misalign;
    logic            r_bubble;

    logic [3:0]      w_be;
    logic            w_misalign;
    logic [15:0]     w_lo;
    logic [XLEN-1:0] w_fmt;

    // Byte enables from the incoming size/address; shifts truncate to 4 bits.
    always_comb begin
        w_be = 4'b1111;
        case (i_mem_size)
            2'b00:   w_be = 4'b0001 << i_mem_addr[1:0];
            2'b01:   w_be = 4'b0011 << {i_mem_addr[1], 1'b0};
            default: w_be = 4'b1111;
        endcase
    end

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_misalign = ((i_mem_size == 2'b01) & i_mem_addr[0]) |
                        (i_mem_size[1] & (i_mem_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Only the low half-word of the lane-shifted read data is ever needed.
    assign w_lo = 16'(i_dmem_rdata >> {r_lane, 3'b000});

    always_comb begin
        w_fmt = i_dmem_rdata;
        case (r_size)
            2'b00:   w_fmt = {{(XLEN-8){~r_unsigned & w_lo[7]}}, w_lo[7:0]};
            2'b01:   w_fmt = {{(XLEN-16){~r_unsigned & w_lo[15]}}, w_lo[15:0]};
            default: w_fmt = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_cmd        <= 1'b0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_lane       <= '0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= '0;
            r_dmem_wdata <= '0;
            r_load_data  <= '0;
            r_misalign   <= 1'b0;
            r_bubble     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!i_bubble && !i_stall) begin
                        r_cmd        <= i_mem_cmd;
                        r_size       <= i_mem_size;
                        r_unsigned   <= i_mem_unsigned;
                        r_lane       <= i_mem_addr[1:0];
                        r_dmem_we    <= i_mem_cmd;
                        r_dmem_addr  <= {i_mem_addr[XLEN-1:2], 2'b00};
                        r_dmem_be    <= w_be;
                        r_dmem_wdata <= i_mem_data;
                        if (w_misalign) begin
                            // Rejected access: skip the memory entirely.
                            r_misalign  <= 1'b1;
                            r_load_data <= '0;
                            r_bubble    <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_dmem_req <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (i_dmem_gnt) begin
                        r_dmem_req <= 1'b0;
                        if (r_cmd) begin
                            r_load_data <= '0;
                            r_bubble    <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_RSP;
                        end
                    end
                end
                S_RSP: begin
                    if (i_dmem_rvalid) begin
                        r_load_data <= w_fmt;
                        r_bubble    <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!i_stall) begin
                        r_load_data <= '0;
                        r_misalign  <= 1'b0;
                        r_bubble    <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stall      = (r_state != S_IDLE) | i_stall;
    assign o_dmem_req   = r_dmem_req;
    assign o_dmem_we    = r_dmem_we;
    assign o_dmem_addr  = r_dmem_addr;
    assign o_dmem_be    = r_dmem_be;
    assign o_dmem_wdata = r_dmem_wdata;
    assign o_load_data  = r_load_data;
    assign o_misalign   = r_misalign;
    assign o_bubble     = r_bubble;

endmodule

// File: tb/tb_dmem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_unit
//   Self-checking bench for dmem_access_unit. A bench-side memory responder
//   applies configurable gnt/rvalid wait states; expected byte enables, load
//   results and latencies come from arithmetic on the access rules.
//   Define DMEM_MISALIGN_CHK_EN here as for the RTL to check that build.
// ---------------------------------------------------------------------------
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        i_mem_cmd = 1'b0;
    logic [31:0] i_mem_addr = '0;
    logic [1:0]  i_mem_size = '0;
    logic        i_mem_unsigned = 1'b0;
    logic [31:0] i_mem_data = '0;
    logic        i_bubble = 1'b1;
    logic        o_stall;
    logic        i_stall = 1'b0;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt = 1'b0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic [31:0] o_load_data;
    logic        o_misalign;
    logic        o_bubble;

    always #5 clk = ~clk;

    dmem_access_unit #(.XLEN(32)) dut (
        .clk(clk), .aresetn(aresetn),
        .i_mem_cmd(i_mem_cmd), .i_mem_addr(i_mem_addr), .i_mem_size(i_mem_size),
        .i_mem_unsigned(i_mem_unsigned), .i_mem_data(i_mem_data), .i_bubble(i_bubble),
        .o_stall(o_stall), .i_stall(i_stall),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_load_data(o_load_data), .o_misalign(o_misalign), .o_bubble(o_bubble)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the last operation driven by run_op.
    logic [31:0] ob_addr, ob_wdata, ob_load;
    logic [3:0]  ob_be;
    logic        ob_we, ob_req_seen, ob_stable, ob_stall_ok, ob_hold_ok;
    logic        ob_idle_ok, ob_accept_ok, ob_misalign, ob_req_done;
    int          ob_lat;

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int lane = int'(a % 4);
        if (sz == 2'd0) return 4'(1 << lane);
        if (sz == 2'd1) return (lane >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
        return (sz == 2'd1 && a % 2 == 1) || (sz >= 2'd2 && a % 4 != 0);
`else
        return (sz == 2'd3 && a == 32'hFFFF_FFFF && 1'b0);
`endif
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
        int unsigned w = rd >> (8 * (a % 4));
        int unsigned v;
        if (sz >= 2'd2) return rd;
        if (sz == 2'd0) begin
            v = w % 256;
            if (!uns && v >= 128) v = v - 256;
        end else begin
            v = w % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic int m_lat(input logic cmd, input logic mis, input int g, input int r);
        if (mis) return 1;
        return cmd ? 2 + g : 3 + g + r;
    endfunction

    // ---------------- driver / memory responder ----------------
    // Entered and left just after a falling edge with the DUT idle.
    task automatic run_op(input logic cmd, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] data, input logic [31:0] rdata,
                          input int g, input int r, input int st);
        int reqw = 0;
        int gcyc = -100;
        i_mem_cmd = cmd; i_mem_addr = addr; i_mem_size = sz;
        i_mem_unsigned = uns; i_mem_data = data; i_bubble = 1'b0;
        #1;
        ob_accept_ok = (o_stall === 1'b0);
        ob_lat = 99; ob_req_seen = 1'b0; ob_stable = 1'b1; ob_stall_ok = 1'b1;
        @(posedge clk); #1;
        i_bubble = 1'b1; i_mem_data = $urandom; i_mem_addr = $urandom;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (o_bubble === 1'b0) begin ob_lat = c; break; end
            if (o_stall !== 1'b1) ob_stall_ok = 1'b0;
            if (o_dmem_req === 1'b1) begin
                if (!ob_req_seen) begin
                    ob_req_seen = 1'b1;
                    ob_addr = o_dmem_addr; ob_be = o_dmem_be;
                    ob_we = o_dmem_we; ob_wdata = o_dmem_wdata;
                end else if ({o_dmem_addr, o_dmem_be, o_dmem_we, o_dmem_wdata} !==
                             {ob_addr, ob_be, ob_we, ob_wdata}) begin
                    ob_stable = 1'b0;
                end
                if (reqw == g) begin i_dmem_gnt = 1'b1; gcyc = c; end
                reqw++;
            end
            if (!cmd && gcyc > 0 && c == gcyc + 1 + r) begin
                i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
            end
            @(posedge clk); #1;
            i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = $urandom;
        end
        ob_load = o_load_data; ob_misalign = o_misalign; ob_req_done = o_dmem_req;
        if (o_stall !== 1'b1) ob_stall_ok = 1'b0;
        ob_hold_ok = 1'b1;
        if (st > 0) begin
            i_stall = 1'b1;
            for (int k = 0; k < st; k++) begin
                @(negedge clk);
                if (o_bubble !== 1'b0 || o_load_data !== ob_load ||
                    o_misalign !== ob_misalign || o_stall !== 1'b1) ob_hold_ok = 1'b0;
            end
            i_stall = 1'b0;
        end
        @(negedge clk);
        ob_idle_ok = (o_bubble === 1'b1 && o_stall === 1'b0 && o_dmem_req === 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({o_bubble, o_dmem_req, o_stall, o_misalign, o_load_data} !== {3'b100, 1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_hold: bubble/req/stall=%b%b%b misalign=%b load=%h, expected 100 0 0",
                         o_bubble, o_dmem_req, o_stall, o_misalign, o_load_data);
            end
        end
        aresetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({o_bubble, o_dmem_req, o_stall} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_idle: bubble/req/stall=%b%b%b, expected 100",
                         o_bubble, o_dmem_req, o_stall);
            end
        end
    endtask

    task automatic test_load_byte();
        run_op(1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 32'h8000_0000, 0, 0, 0);
        n_checks++; if (ob_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b, expected 1000", ob_be); end
        n_checks++; if (ob_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h, expected 00000100", ob_addr); end
        n_checks++; if (ob_we !== 1'b0) begin n_fail++; $display("FAIL lb_we: got %b, expected 0", ob_we); end
        n_checks++; if (ob_lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d, expected 3", ob_lat); end
        n_checks++; if (ob_load !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h, expected ffffff80", ob_load); end
        n_checks++; if (ob_idle_ok !== 1'b1) begin n_fail++; $display("FAIL lb_idle: got %b, expected 1", ob_idle_ok); end
        run_op(1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 32'h8000_0000, 0, 0, 0);
        n_checks++; if (ob_load !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data: got %h, expected 00000080", ob_load); end
    endtask

    task automatic test_store_half();
        run_op(1'b1, 32'h202, 2'd1, 1'b0, 32'hBEEF_0000, 32'h0, 0, 0, 0);
        n_checks++; if (ob_we !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b, expected 1", ob_we); end
        n_checks++; if (ob_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b, expected 1100", ob_be); end
        n_checks++; if (ob_wdata !== 32'hBEEF_0000) begin n_fail++; $display("FAIL sh_wdata: got %h, expected beef0000", ob_wdata); end
        n_checks++; if (ob_addr !== 32'h200) begin n_fail++; $display("FAIL sh_addr: got %h, expected 00000200", ob_addr); end
        n_checks++; if (ob_lat !== 2) begin n_fail++; $display("FAIL sh_latency: got %0d, expected 2", ob_lat); end
        n_checks++; if (ob_load !== 32'h0) begin n_fail++; $display("FAIL sh_data: got %h, expected 00000000", ob_load); end
    endtask

    task automatic test_wait_states();
        run_op(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 3, 2, 0);
        n_checks++; if (ob_stable !== 1'b1) begin n_fail++; $display("FAIL lw_req_stable: got %b, expected 1", ob_stable); end
        n_checks++; if (ob_stall_ok !== 1'b1) begin n_fail++; $display("FAIL lw_stall: got %b, expected 1", ob_stall_ok); end
        n_checks++; if (ob_lat !== 8) begin n_fail++; $display("FAIL lw_latency: got %0d, expected 8", ob_lat); end
        n_checks++; if (ob_load !== 32'h1234_5678) begin n_fail++; $display("FAIL lw_data: got %h, expected 12345678", ob_load); end
        n_checks++; if (ob_req_done !== 1'b0) begin n_fail++; $display("FAIL lw_req_drop: got %b, expected 0", ob_req_done); end
    endtask

    task automatic test_done_stall();
        run_op(1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 32'hA5C3_1111, 1, 1, 4);
        n_checks++; if (ob_load !== 32'hFFFF_A5C3) begin n_fail++; $display("FAIL ds_data: got %h, expected ffffa5c3", ob_load); end
        n_checks++; if (ob_hold_ok !== 1'b1) begin n_fail++; $display("FAIL ds_hold: got %b, expected 1", ob_hold_ok); end
        n_checks++; if (ob_idle_ok !== 1'b1) begin n_fail++; $display("FAIL ds_idle: got %b, expected 1", ob_idle_ok); end
    endtask

    task automatic test_reset_in_rsp();
        i_mem_cmd = 1'b0; i_mem_addr = 32'h80; i_mem_size = 2'd2; i_bubble = 1'b0;
        @(posedge clk); #1; i_bubble = 1'b1;
        @(negedge clk);
        n_checks++; if (o_dmem_req !== 1'b1) begin n_fail++; $display("FAIL rr_req: got %b, expected 1", o_dmem_req); end
        i_dmem_gnt = 1'b1;
        @(posedge clk); #1; i_dmem_gnt = 1'b0;
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({o_bubble, o_dmem_req, o_stall} !== 3'b100) begin
            n_fail++; $display("FAIL rr_async: bubble/req/stall=%b%b%b, expected 100", o_bubble, o_dmem_req, o_stall);
        end
        @(negedge clk); aresetn = 1'b1;
        @(negedge clk); i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF; i_dmem_gnt = 1'b1;
        @(posedge clk); #1; i_dmem_rvalid = 1'b0; i_dmem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({o_bubble, o_stall, o_dmem_req, o_load_data} !== {3'b100, 32'h0}) begin
                n_fail++;
                $display("FAIL rr_late_rvalid: bubble/stall/req=%b%b%b load=%h, expected 100 00000000",
                         o_bubble, o_stall, o_dmem_req, o_load_data);
            end
        end
    endtask

    task automatic test_misalign();
        run_op(1'b0, 32'h41, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
`ifdef DMEM_MISALIGN_CHK_EN
        n_checks++; if (ob_req_seen !== 1'b0) begin n_fail++; $display("FAIL mis_noreq: got %b, expected 0", ob_req_seen); end
        n_checks++; if (ob_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b, expected 1", ob_misalign); end
        n_checks++; if (ob_load !== 32'h0) begin n_fail++; $display("FAIL mis_data: got %h, expected 00000000", ob_load); end
        n_checks++; if (ob_lat !== 1) begin n_fail++; $display("FAIL mis_latency: got %0d, expected 1", ob_lat); end
`else
        n_checks++; if (ob_be !== 4'b1111) begin n_fail++; $display("FAIL mis_be: got %b, expected 1111", ob_be); end
        n_checks++; if (ob_addr !== 32'h40) begin n_fail++; $display("FAIL mis_addr: got %h, expected 00000040", ob_addr); end
        n_checks++; if (ob_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got %b, expected 0", ob_misalign); end
        n_checks++; if (ob_load !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mis_data: got %h, expected cafef00d", ob_load); end
`endif
    endtask

    task automatic test_back_to_back();
        // Second op is presented in the single idle cycle after the first completes.
        run_op(1'b1, 32'h300, 2'd2, 1'b0, 32'h0BAD_F00D, 32'h0, 0, 0, 0);
        n_checks++; if (ob_idle_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: got %b, expected 1", ob_idle_ok); end
        run_op(1'b0, 32'h301, 2'd0, 1'b1, 32'h0, 32'h0000_7F00, 0, 0, 0);
        n_checks++; if (ob_accept_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b, expected 1", ob_accept_ok); end
        n_checks++; if (ob_lat !== 3) begin n_fail++; $display("FAIL b2b_latency: got %0d, expected 3", ob_lat); end
        n_checks++; if (ob_load !== 32'h0000_007F) begin n_fail++; $display("FAIL b2b_data: got %h, expected 0000007f", ob_load); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic        cmd  = 1'($urandom_range(0, 1));
            logic [1:0]  sz   = 2'($urandom_range(0, 3));
            logic        uns  = 1'($urandom_range(0, 1));
            logic [31:0] addr = ($urandom_range(0, 1023) * 4) + $urandom_range(0, 3);
            logic [31:0] data = $urandom;
            logic [31:0] rd   = $urandom;
            int          g    = $urandom_range(0, 3);
            int          r    = $urandom_range(0, 3);
            int          st   = $urandom_range(0, 2);
            logic        mis  = m_mis(sz, addr);
            logic [31:0] exp_ld = (mis || cmd) ? 32'h0 : m_load(sz, uns, addr, rd);
            int          exp_lat = m_lat(cmd, mis, g, r);
            run_op(cmd, addr, sz, uns, data, rd, g, r, st);
            n_checks++;
            if (ob_lat !== exp_lat || ob_load !== exp_ld || ob_misalign !== mis) begin
                n_fail++;
                $display("FAIL rnd_result[%0d]: lat=%0d data=%h mis=%b, expected lat=%0d data=%h mis=%b (cmd=%b sz=%0d addr=%h)",
                         n, ob_lat, ob_load, ob_misalign, exp_lat, exp_ld, mis, cmd, sz, addr);
            end
            n_checks++;
            if (mis ? (ob_req_seen !== 1'b0)
                    : ({ob_req_seen, ob_addr, ob_be, ob_we} !== {1'b1, addr & 32'hFFFF_FFFC, m_be(sz, addr), cmd} ||
                       (cmd && ob_wdata !== data))) begin
                n_fail++;
                $display("FAIL rnd_request[%0d]: seen=%b addr=%h be=%b we=%b wdata=%h, expected addr=%h be=%b we=%b wdata=%h",
                         n, ob_req_seen, ob_addr, ob_be, ob_we, ob_wdata,
                         addr & 32'hFFFF_FFFC, m_be(sz, addr), cmd, data);
            end
            n_checks++;
            if ({ob_accept_ok, ob_stable, ob_stall_ok, ob_hold_ok, ob_idle_ok} !== 5'b11111) begin
                n_fail++;
                $display("FAIL rnd_handshake[%0d]: accept/stable/stall/hold/idle=%b, expected 11111",
                         n, {ob_accept_ok, ob_stable, ob_stall_ok, ob_hold_ok, ob_idle_ok});
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_wait_states();
        test_done_stall();
        test_reset_in_rsp();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
